// File: rtl/sp_ram_responder_if.sv
// Single-port block-RAM bus between the memory write/read controllers and sp_ram_responder.
// Access counters (wr_cnt/rd_cnt) exist only when SP_RAM_ACCESS_CNT_EN is defined.
interface sp_ram_responder_if #(
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 4
);
    logic          mem_ena;
    logic [0:0]    mem_wea;
    logic [AW-1:0] mem_addra;
    logic [DW-1:0] mem_dina;
    logic [DW-1:0] mem_douta;
    logic          rd_valid;
    logic          busy;
`ifdef SP_RAM_ACCESS_CNT_EN
    logic [15:0]   wr_cnt;
    logic [15:0]   rd_cnt;

    modport master (
        output mem_ena, mem_wea, mem_addra, mem_dina,
        input  mem_douta, rd_valid, busy, wr_cnt, rd_cnt
    );
    modport slave (
        input  mem_ena, mem_wea, mem_addra, mem_dina,
        output mem_douta, rd_valid, busy, wr_cnt, rd_cnt
    );
`else
    modport master (
        output mem_ena, mem_wea, mem_addra, mem_dina,
        input  mem_douta, rd_valid, busy
    );
    modport slave (
        input  mem_ena, mem_wea, mem_addra, mem_dina,
        output mem_douta, rd_valid, busy
    );
`endif
endinterface

// File: rtl/sp_ram_responder.sv
// Behavioural single-port BRAM responder: post-reset clear, 1/2-cycle read latency, write-port output modes.
// Define SP_RAM_ACCESS_CNT_EN to add saturating write/read access counters on the bus.
module sp_ram_responder #(
    parameter int unsigned   DW         = 16,
    parameter int unsigned   AW         = 4,
    parameter int unsigned   RD_LAT     = 1,
    parameter int unsigned   WRITE_MODE = 0,
    parameter logic [DW-1:0] INIT_VAL   = '0
) (
    input logic               clk_g,
    input logic               rst,
    sp_ram_responder_if.slave bus
);

    localparam int unsigned   DEPTH          = 2 ** AW;
    localparam logic [AW-1:0] LAST_ADDR      = AW'(DEPTH - 1);
    localparam int unsigned   WM_READ_FIRST  = 0;
    localparam int unsigned   WM_WRITE_FIRST = 1;
    localparam int unsigned   WM_NO_CHANGE   = 2;

    if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_rd_lat
        $error("sp_ram_responder: RD_LAT must be 1 or 2");
    end
    if (WRITE_MODE > WM_NO_CHANGE) begin : g_bad_write_mode
        $error("sp_ram_responder: WRITE_MODE must be 0, 1 or 2");
    end

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [AW-1:0] clr_addr;
    logic [AW-1:0] clr_addr_nx;

    logic          mem_we_c;
    logic [AW-1:0] mem_wa_c;
    logic [DW-1:0] mem_wd_c;
    logic          rd_acc_c;
    logic          wr_acc_c;
    logic          port_upd_c;
    logic [DW-1:0] port_data_c;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] douta_q;
    logic          rd_valid_q;
    logic          busy_q;

    always_ff @(posedge clk_g or posedge rst) begin
        if (rst) begin
            state    <= S_CLEAR;
            clr_addr <= '0;
        end else begin
            state    <= state_nx;
            clr_addr <= clr_addr_nx;
        end
    end

    // Clear sequence owns the array write port; in RUN the bus owns it.
    always_comb begin
        state_nx    = state;
        clr_addr_nx = clr_addr;
        mem_we_c    = 1'b0;
        mem_wa_c    = bus.mem_addra;
        mem_wd_c    = bus.mem_dina;
        rd_acc_c    = 1'b0;
        wr_acc_c    = 1'b0;
        case (state)
            S_CLEAR: begin
                mem_we_c    = 1'b1;
                mem_wa_c    = clr_addr;
                mem_wd_c    = INIT_VAL;
                clr_addr_nx = clr_addr + AW'(1);
                if (clr_addr == LAST_ADDR) begin
                    state_nx = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.mem_ena) begin
                    // An unknown write enable falls to the read branch: no array update.
                    if (bus.mem_wea[0]) begin
                        wr_acc_c = 1'b1;
                        mem_we_c = 1'b1;
                    end else begin
                        rd_acc_c = 1'b1;
                    end
                end
            end
            default: state_nx = S_CLEAR;
        endcase
    end

    always_ff @(posedge clk_g) begin
        if (mem_we_c) begin
            mem[mem_wa_c] <= mem_wd_c;
        end
    end

    // Port data as seen before this edge's write lands, so read-first sees the old word.
    always_comb begin
        port_upd_c  = rd_acc_c;
        port_data_c = mem[bus.mem_addra];
        if (wr_acc_c) begin
            if (WRITE_MODE == WM_READ_FIRST) begin
                port_upd_c = 1'b1;
            end else if (WRITE_MODE == WM_WRITE_FIRST) begin
                port_upd_c  = 1'b1;
                port_data_c = bus.mem_dina;
            end else begin
                port_upd_c = 1'b0;
            end
        end
    end

    if (RD_LAT == 1) begin : g_lat1
        always_ff @(posedge clk_g or posedge rst) begin
            if (rst) begin
                douta_q    <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                if (port_upd_c) begin
                    douta_q <= port_data_c;
                end
                rd_valid_q <= rd_acc_c;
            end
        end
    end else begin : g_lat2
        logic          p1_upd;
        logic          p1_rd;
        logic [DW-1:0] p1_data;

        always_ff @(posedge clk_g or posedge rst) begin
            if (rst) begin
                p1_upd     <= 1'b0;
                p1_rd      <= 1'b0;
                p1_data    <= '0;
                douta_q    <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                p1_upd  <= port_upd_c;
                p1_rd   <= rd_acc_c;
                p1_data <= port_data_c;
                if (p1_upd) begin
                    douta_q <= p1_data;
                end
                rd_valid_q <= p1_rd;
            end
        end
    end

    // busy falls on the same edge that writes the last word of the clear.
    always_ff @(posedge clk_g or posedge rst) begin
        if (rst) begin
            busy_q <= 1'b1;
        end else begin
            busy_q <= (state_nx == S_CLEAR);
        end
    end

    assign bus.mem_douta = douta_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.busy      = busy_q;

`ifdef SP_RAM_ACCESS_CNT_EN
    logic [15:0] wr_cnt_q;
    logic [15:0] rd_cnt_q;

    always_ff @(posedge clk_g or posedge rst) begin
        if (rst) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            if (wr_acc_c && (wr_cnt_q != 16'hFFFF)) begin
                wr_cnt_q <= wr_cnt_q + 16'd1;
            end
            if (rd_acc_c && (rd_cnt_q != 16'hFFFF)) begin
                rd_cnt_q <= rd_cnt_q + 16'd1;
            end
        end
    end

    assign bus.wr_cnt = wr_cnt_q;
    assign bus.rd_cnt = rd_cnt_q;
`endif

endmodule

// File: tb/tb_sp_ram_responder.sv
// Bench for sp_ram_responder: four instances (lat1 WM0/1/2, lat2 WM0) driven from one stimulus bus.
// Counter checks run only when SP_RAM_ACCESS_CNT_EN is defined.
module tb_sp_ram_responder;

    logic        clk;
    logic        rst;
    logic        ena;
    logic [0:0]  wea;
    logic [3:0]  addr;
    logic [15:0] din;

    logic [15:0] douta [4];
    logic        rdv   [4];
    logic        bsy   [4];
`ifdef SP_RAM_ACCESS_CNT_EN
    logic [15:0] wrc   [4];
    logic [15:0] rdc   [4];
`endif

    int checks   = 0;
    int failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        sp_ram_responder_if #(.DW(16), .AW(4)) bus ();
        assign bus.mem_ena   = ena;
        assign bus.mem_wea   = wea;
        assign bus.mem_addra = addr;
        assign bus.mem_dina  = din;
        sp_ram_responder #(
            .DW(16), .AW(4),
            .RD_LAT((g == 3) ? 2 : 1),
            .WRITE_MODE((g == 3) ? 0 : g),
            .INIT_VAL(16'h0000)
        ) dut (
            .clk_g(clk),
            .rst(rst),
            .bus(bus)
        );
        assign douta[g] = bus.mem_douta;
        assign rdv[g]   = bus.rd_valid;
        assign bsy[g]   = bus.busy;
`ifdef SP_RAM_ACCESS_CNT_EN
        assign wrc[g]   = bus.wr_cnt;
        assign rdc[g]   = bus.rd_cnt;
`endif
    end

    typedef struct {
        logic             ena;
        logic             wea;
        logic [3:0]       addr;
        logic [15:0]      din;
        logic [3:0]       ev;
        logic [3:0][15:0] ed;
    } vec_t;

    vec_t tbl [34];

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input int g, input logic v, input logic [15:0] d);
        check($sformatf("%s_rdv%0d", tag, g), 16'(rdv[g]), 16'(v));
        check($sformatf("%s_dout%0d", tag, g), douta[g], d);
    endtask

    task automatic run_clear(input string tag);
        for (int i = 1; i <= 16; i++) begin
            tick();
            for (int g = 0; g < 4; g++) begin
                check($sformatf("%s_busy%0d_c%0d", tag, g, i), 16'(bsy[g]), 16'(i < 16));
            end
            check($sformatf("%s_clr_rdv_c%0d", tag, i), 16'(rdv[0]), 16'h0);
        end
    endtask

    initial begin
        logic [15:0] pat;

        // Writes k, back-to-back reads k, two idles; lane 3 (lat2) lags lane 0 by one edge.
        for (int k = 0; k < 16; k++) begin
            pat = 16'((32'd2 << k) - 32'd1);
            tbl[k].ena = 1'b1; tbl[k].wea = 1'b1; tbl[k].addr = 4'(k); tbl[k].din = pat;
            tbl[k].ev = 4'b0000;
            tbl[k].ed[0] = 16'h0000; tbl[k].ed[1] = pat; tbl[k].ed[2] = 16'h0000;
            tbl[16+k].ena = 1'b1; tbl[16+k].wea = 1'b0; tbl[16+k].addr = 4'(k); tbl[16+k].din = 16'h0;
            tbl[16+k].ev = 4'b0111;
            tbl[16+k].ed[0] = pat; tbl[16+k].ed[1] = pat; tbl[16+k].ed[2] = pat;
        end
        for (int i = 32; i < 34; i++) begin
            tbl[i].ena = 1'b0; tbl[i].wea = 1'b0; tbl[i].addr = 4'h0; tbl[i].din = 16'h0;
            tbl[i].ev = 4'b0000;
            tbl[i].ed[0] = 16'hFFFF; tbl[i].ed[1] = 16'hFFFF; tbl[i].ed[2] = 16'hFFFF;
        end
        for (int i = 0; i < 34; i++) begin
            tbl[i].ev[3] = (i == 0) ? 1'b0 : tbl[i-1].ev[0];
            tbl[i].ed[3] = (i == 0) ? 16'h0000 : tbl[i-1].ed[0];
        end

        // Reset with a pending write to word 3 that the clear must ignore.
        rst = 1'b1; ena = 1'b1; wea = 1'b1; addr = 4'd3; din = 16'h00FF;
        tick(); tick();
        for (int g = 0; g < 4; g++) begin
            check_out("rst", g, 1'b0, 16'h0000);
            check($sformatf("rst_busy%0d", g), 16'(bsy[g]), 16'h1);
        end
        rst = 1'b0;
        run_clear("clr1");
        ena = 1'b0;

        wea = 1'b0; ena = 1'b1; addr = 4'd3;
        tick(); ena = 1'b0;
        check_out("rd3_n", 0, 1'b1, 16'h0000);
        check("rd3_n_rdv3", 16'(rdv[3]), 16'h0);
        tick();
        check_out("rd3_n1", 3, 1'b1, 16'h0000);
        check("rd3_n1_rdv0", 16'(rdv[0]), 16'h0);

        for (int i = 0; i < 34; i++) begin
            ena = tbl[i].ena; wea = tbl[i].wea; addr = tbl[i].addr; din = tbl[i].din;
            tick();
            for (int g = 0; g < 4; g++) begin
                check_out($sformatf("vec%0d", i), g, tbl[i].ev[g], tbl[i].ed[g]);
            end
        end

        // Single read of word 5, then write 1234 over word 7 (holds 00FF).
        ena = 1'b1; wea = 1'b0; addr = 4'd5;
        tick();
        for (int g = 0; g < 3; g++) check_out("rd5", g, 1'b1, 16'h003F);
        check_out("rd5_lat2_early", 3, 1'b0, 16'hFFFF);
        wea = 1'b1; addr = 4'd7; din = 16'h1234;
        tick();
        ena = 1'b0; wea = 1'b0;
        check_out("wm0", 0, 1'b0, 16'h00FF);
        check_out("wm1", 1, 1'b0, 16'h1234);
        check_out("wm2", 2, 1'b0, 16'h003F);
        check_out("rd5_lat2", 3, 1'b1, 16'h003F);
        tick();
        check_out("wm0_lat2", 3, 1'b0, 16'h00FF);
        check_out("wm0_hold", 0, 1'b0, 16'h00FF);
        ena = 1'b1; addr = 4'd7;
        tick();
        ena = 1'b0;
        for (int g = 0; g < 3; g++) check_out("rd7", g, 1'b1, 16'h1234);
        tick();
        check_out("rd7_lat2", 3, 1'b1, 16'h1234);

        // Reset lands while a lat2 read is in flight.
        ena = 1'b1; addr = 4'd7;
        tick();
        ena = 1'b0;
        rst = 1'b1;
        #1;
        check_out("midrst", 3, 1'b0, 16'h0000);
        for (int g = 0; g < 4; g++) check($sformatf("midrst_busy%0d", g), 16'(bsy[g]), 16'h1);
        tick();
        check("midrst_late_rdv3", 16'(rdv[3]), 16'h0);
        tick();
        rst = 1'b0;
        run_clear("clr2");
        for (int k = 0; k < 16; k++) begin
            ena = 1'b1; wea = 1'b0; addr = 4'(k);
            tick();
            check_out($sformatf("init_rd%0d", k), 0, 1'b1, 16'h0000);
            if (k > 0) check_out($sformatf("init_rd%0d_lat2", k - 1), 3, 1'b1, 16'h0000);
        end
        ena = 1'b0;
        tick();
        check_out("init_rd15_lat2", 3, 1'b1, 16'h0000);
        tick();
        check("drain_rdv3", 16'(rdv[3]), 16'h0);

`ifdef SP_RAM_ACCESS_CNT_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        run_clear("clr3");
        check("cnt_after_clr_wr", wrc[0], 16'd0);
        for (int i = 0; i < 10; i++) begin
            ena = (i < 8); wea = (i < 3); addr = 4'(i); din = 16'(i);
            tick();
        end
        ena = 1'b0;
        check("cnt_wr", wrc[0], 16'd3);
        check("cnt_rd", rdc[0], 16'd5);
        check("cnt_wr_lat2", wrc[3], 16'd3);
        check("cnt_rd_lat2", rdc[3], 16'd5);
        rst = 1'b1;
        #1;
        check("cnt_rst_wr", wrc[0], 16'd0);
        check("cnt_rst_rd", rdc[0], 16'd0);
        rst = 1'b0;
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
